// File: rtl/elliptic_curve_structs.sv
// Shared elliptic-curve types for the point arithmetic blocks.
//   curve_point_t : affine point, one COORD_W-bit word per coordinate
//   inf_point     : point at infinity (group identity)
//   mul_mode_e    : scalar-multiplication algorithm select
//   mul_state_e   : scalar multiplier control states
package elliptic_curve_structs;

  localparam int COORD_W = 32;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } curve_point_t;

  localparam curve_point_t inf_point = '{x: {COORD_W{1'b0}}, y: {COORD_W{1'b0}}};

  typedef enum logic {
    MUL_DAA    = 1'b0,
    MUL_LADDER = 1'b1
  } mul_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    STEP   = 3'd4,
    DONE   = 3'd5
  } mul_state_e;

  // Componentwise group law of the arithmetic model used by point_add / point_double.
  function automatic curve_point_t point_sum(input curve_point_t a, input curve_point_t b);
    curve_point_t r;
    r.x = a.x + b.x;
    r.y = a.y + b.y;
    return r;
  endfunction

endpackage

// File: rtl/point_add.sv
// Multi-cycle point adder R = A + B.
//   clk, Reset (active-high, synchronous, restarts the operation)
//   A, B : operands, held stable until Done
//   R    : sum, valid while Done is high
//   Done : rises LATENCY cycles after Reset is released and stays high
// inf_point is the identity, so an infinite operand returns the other one.
module point_add
  import elliptic_curve_structs::*;
#(
  parameter int LATENCY = 3
) (
  input  logic         clk,
  input  logic         Reset,
  input  curve_point_t A,
  input  curve_point_t B,
  output curve_point_t R,
  output logic         Done
);

  localparam logic [2:0] CNT_LAST = 3'(LATENCY - 1);

  logic [2:0]   cnt_r;
  logic         done_r;
  curve_point_t r_r;

  // Latency counter and result register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_r  <= 3'd0;
      done_r <= 1'b0;
      r_r    <= inf_point;
    end else begin
      r_r <= point_sum(A, B);
      if (!done_r) begin
        if (cnt_r == CNT_LAST) begin
          done_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + 3'd1;
        end
      end
    end
  end

  assign R    = r_r;
  assign Done = done_r;

endmodule

// File: rtl/point_double.sv
// Multi-cycle point doubler R = 2P.
//   clk, Reset (active-high, synchronous, restarts the operation)
//   P    : operand, held stable until Done
//   R    : result, valid while Done is high
//   Done : rises LATENCY cycles after Reset is released and stays high
module point_double
  import elliptic_curve_structs::*;
#(
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         Reset,
  input  curve_point_t P,
  output curve_point_t R,
  output logic         Done
);

  localparam logic [2:0] CNT_LAST = 3'(LATENCY - 1);

  logic [2:0]   cnt_r;
  logic         done_r;
  curve_point_t r_r;

  // Latency counter and result register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_r  <= 3'd0;
      done_r <= 1'b0;
      r_r    <= inf_point;
    end else begin
      r_r <= point_sum(P, P);
      if (!done_r) begin
        if (cnt_r == CNT_LAST) begin
          done_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + 3'd1;
        end
      end
    end
  end

  assign R    = r_r;
  assign Done = done_r;

endmodule

// File: rtl/point_mul_operand_mux.sv
// Operand and write-back selection for one scalar-multiplication iteration.
//   mode, k_bit       : algorithm and current scalar bit
//   acc, jpt          : A/J (double-and-add) or R0/R1 (ladder)
//   add_res, dbl_res  : results of the add and double units
//   add_a, add_b, dbl_in : operands for the units
//   acc_next, jpt_next   : register values written in STEP
module point_mul_operand_mux
  import elliptic_curve_structs::*;
(
  input  mul_mode_e    mode,
  input  logic         k_bit,
  input  curve_point_t acc,
  input  curve_point_t jpt,
  input  curve_point_t add_res,
  input  curve_point_t dbl_res,
  output curve_point_t add_a,
  output curve_point_t add_b,
  output curve_point_t dbl_in,
  output curve_point_t acc_next,
  output curve_point_t jpt_next
);

  // Both algorithms always add the two registers; only the doubling operand and write-back differ.
  always_comb begin
    add_a    = acc;
    add_b    = jpt;
    dbl_in   = jpt;
    acc_next = acc;
    jpt_next = jpt;
    case (mode)
      MUL_DAA: begin
        jpt_next = dbl_res;
        if (k_bit) begin
          acc_next = add_res;
        end else begin
          acc_next = acc;
        end
      end
      MUL_LADDER: begin
        if (k_bit) begin
          dbl_in   = jpt;
          acc_next = add_res;
          jpt_next = dbl_res;
        end else begin
          dbl_in   = acc;
          acc_next = dbl_res;
          jpt_next = add_res;
        end
      end
      default: begin
        acc_next = acc;
        jpt_next = jpt;
      end
    endcase
  end

endmodule

// File: rtl/point_mul_scalar_seq.sv
// Sequential scalar multiplier R = k*P.
//   clk, Reset_n (synchronous, active-low)
//   in_valid/in_ready, in_mode, in_P, in_k : job input handshake
//   out_valid/out_ready, out_R             : result handshake, out_R held while stalled
//   busy                                   : job in flight (LOAD..STEP)
// Mode 0: LSB-first double-and-add with zero-bit add skipping and early exit.
// Mode 1: MSB-first Montgomery ladder, always K_WIDTH iterations.
module point_mul_scalar_seq
  import elliptic_curve_structs::*;
#(
  parameter int K_WIDTH = 256,
  parameter int CNT_W   = $clog2(K_WIDTH + 1)
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  curve_point_t       in_P,
  input  logic [K_WIDTH-1:0] in_k,
  output logic               out_valid,
  input  logic               out_ready,
  output curve_point_t       out_R,
  output logic               busy
);

  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(K_WIDTH - 1);
  localparam logic [K_WIDTH-1:0] K_ZERO   = {K_WIDTH{1'b0}};
  localparam logic [K_WIDTH-1:0] K_ONE    = {{(K_WIDTH-1){1'b0}}, 1'b1};

  mul_state_e         state_r, state_s;
  mul_mode_e          mode_r;
  logic [K_WIDTH-1:0] k_r;
  curve_point_t       p_r;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  curve_point_t       acc_r, acc_s, jpt_r, jpt_s;
  logic               in_ready_r, out_valid_r, busy_r;
  curve_point_t       out_r_r;

  logic               unit_rst_s, add_done_s, dbl_done_s, units_done_s;
  curve_point_t       add_a_s, add_b_s, dbl_in_s, add_res_s, dbl_res_s, acc_nx_s, jpt_nx_s;
  logic [K_WIDTH-1:0] k_shift_s;
  logic               k_bit_s, k_rest_zero_s;

  // Bit under the counter, and whether any higher bit remains (early exit test).
  assign k_shift_s     = k_r >> cnt_r;
  assign k_bit_s       = k_shift_s[0];
  assign k_rest_zero_s = (k_shift_s[K_WIDTH-1:1] == {(K_WIDTH-1){1'b0}});

  // Units restart on every LAUNCH and are held reset along with the block.
  assign unit_rst_s = (state_r == LAUNCH) || !Reset_n;
  // Double-and-add only needs the adder when the scalar bit is set.
  assign units_done_s = dbl_done_s && (add_done_s || ((mode_r == MUL_DAA) && !k_bit_s));

  point_mul_operand_mux u_mux (
    .mode     (mode_r),
    .k_bit    (k_bit_s),
    .acc      (acc_r),
    .jpt      (jpt_r),
    .add_res  (add_res_s),
    .dbl_res  (dbl_res_s),
    .add_a    (add_a_s),
    .add_b    (add_b_s),
    .dbl_in   (dbl_in_s),
    .acc_next (acc_nx_s),
    .jpt_next (jpt_nx_s)
  );

  point_add u_add (
    .clk   (clk),
    .Reset (unit_rst_s),
    .A     (add_a_s),
    .B     (add_b_s),
    .R     (add_res_s),
    .Done  (add_done_s)
  );

  point_double u_dbl (
    .clk   (clk),
    .Reset (unit_rst_s),
    .P     (dbl_in_s),
    .R     (dbl_res_s),
    .Done  (dbl_done_s)
  );

  // Next-state and datapath register updates.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    acc_s   = acc_r;
    jpt_s   = jpt_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        acc_s = inf_point;
        jpt_s = p_r;
        if (mode_r == MUL_DAA) begin
          cnt_s = CNT_ZERO;
          if (k_r == K_ZERO) begin
            state_s = DONE;
          end else if (k_r == K_ONE) begin
            acc_s   = p_r;
            state_s = DONE;
          end else begin
            state_s = LAUNCH;
          end
        end else begin
          cnt_s   = CNT_LAST;
          state_s = LAUNCH;
        end
      end
      LAUNCH: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (units_done_s) begin
          state_s = STEP;
        end else begin
          state_s = WAIT;
        end
      end
      STEP: begin
        acc_s = acc_nx_s;
        jpt_s = jpt_nx_s;
        if (mode_r == MUL_DAA) begin
          cnt_s = cnt_r + CNT_ONE;
          if ((cnt_r == CNT_LAST) || k_rest_zero_s) begin
            state_s = DONE;
          end else begin
            state_s = LAUNCH;
          end
        end else begin
          // Ladder ends after the bit-0 iteration, so the counter never goes below zero.
          if (cnt_r == CNT_ZERO) begin
            state_s = DONE;
          end else begin
            cnt_s   = cnt_r - CNT_ONE;
            state_s = LAUNCH;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, job registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_r     <= IDLE;
      mode_r      <= MUL_DAA;
      k_r         <= K_ZERO;
      p_r         <= inf_point;
      cnt_r       <= CNT_ZERO;
      acc_r       <= inf_point;
      jpt_r       <= inf_point;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_r_r     <= inf_point;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      acc_r   <= acc_s;
      jpt_r   <= jpt_s;
      if ((state_r == IDLE) && in_valid && in_ready_r) begin
        mode_r <= mul_mode_e'(in_mode);
        k_r    <= in_k;
        p_r    <= in_P;
      end
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s == LOAD) || (state_s == LAUNCH) ||
                     (state_s == WAIT) || (state_s == STEP);
      if (state_s == DONE) begin
        out_r_r <= acc_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_R     = out_r_r;

endmodule

// File: tb/tb_point_mul_scalar_seq.sv
// Self-checking bench for point_mul_scalar_seq (K_WIDTH = 256).
// Reference: in the componentwise-addition group modulo 2^32, k*P is simply
// (k mod 2^32) times each coordinate; iteration counts follow from the scalar's MSB.
module tb_point_mul_scalar_seq;
  import elliptic_curve_structs::*;

  localparam int KW = 256;
  localparam int TMO = 20000;

  logic          clk = 1'b0;
  logic          Reset_n;
  logic          in_valid, in_ready, in_mode, out_valid, out_ready, busy;
  curve_point_t  in_P, out_R;
  logic [KW-1:0] in_k;

  int n_assert = 0;
  int n_fail   = 0;
  int launch_total = 0;

  point_mul_scalar_seq #(.K_WIDTH(KW)) dut (
    .clk(clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_P(in_P), .in_k(in_k), .out_valid(out_valid),
    .out_ready(out_ready), .out_R(out_R), .busy(busy)
  );

  always #5 clk = ~clk;

  // Count LAUNCH cycles as they complete.
  always @(posedge clk) begin
    if (dut.state_r == LAUNCH) launch_total <= launch_total + 1;
  end

  function automatic curve_point_t ref_mul(input logic [KW-1:0] k, input curve_point_t p);
    curve_point_t r;
    logic [31:0] km;
    km  = k[31:0];
    r.x = km * p.x;
    r.y = km * p.y;
    return r;
  endfunction

  function automatic int ref_launches(input logic mode, input logic [KW-1:0] k);
    int msb;
    msb = -1;
    for (int i = 0; i < KW; i++) if (k[i]) msb = i;
    if (mode) return KW;
    if (msb < 1) return 0;
    return msb + 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid; returns cycles counted from the accept cycle.
  task automatic wait_out(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
  endtask

  // One complete job; called at posedge+1.
  task automatic run_job(input string tag, input logic mode, input logic [KW-1:0] k,
                         input curve_point_t p, output curve_point_t res,
                         output int launches, output int lat);
    int n, start;
    in_valid = 1'b1; in_mode = mode; in_k = k; in_P = p;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    start = launch_total;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(tag, lat);
    res = out_R;
    launches = launch_total - start;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic job_check(input string tag, input logic mode, input logic [KW-1:0] k,
                           input curve_point_t p);
    curve_point_t res;
    int launches, lat;
    run_job(tag, mode, k, p, res, launches, lat);
    check({tag, "_R"}, res, ref_mul(k, p));
    check({tag, "_launches"}, 64'(launches), 64'(ref_launches(mode, k)));
  endtask

  curve_point_t G, res, res0, res1, held;
  int launches, lat, lat_a, n, start;
  logic [KW-1:0] kr;

  initial begin
    G = '{x: 32'h1234_5678, y: 32'h9abc_def1};
    Reset_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_P = inf_point;
    in_k = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_R", out_R, inf_point);
    Reset_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // k = 0 in both modes; ladder latency must not depend on k.
    run_job("k0_m0", 1'b0, 256'd0, G, res, launches, lat);
    check("k0_m0_R", res, inf_point);
    check("k0_m0_launches", 64'(launches), 64'd0);
    run_job("k0_m1", 1'b1, 256'd0, G, res, launches, lat_a);
    check("k0_m1_R", res, inf_point);
    check("k0_m1_launches", 64'(launches), 64'(KW));

    // k = 1 shortcut latency, k = 2 is one doubling.
    run_job("k1_m0", 1'b0, 256'd1, G, res, launches, lat);
    check("k1_m0_R", res, G);
    check("k1_m0_latency", 64'(lat), 64'd2);
    run_job("k2_m0", 1'b0, 256'd2, G, res, launches, lat);
    check("k2_m0_R", res, point_sum(G, G));

    // 0x0B and 2^255+1 in both modes.
    run_job("kb_m0", 1'b0, 256'h0b, G, res0, launches, lat);
    check("kb_m0_R", res0, ref_mul(256'h0b, G));
    check("kb_m0_launches", 64'(launches), 64'd4);
    run_job("kb_m1", 1'b1, 256'h0b, G, res1, launches, lat);
    check("kb_m1_R", res1, ref_mul(256'h0b, G));
    check("kb_m1_launches", 64'(launches), 64'd256);
    check("kb_m1_const_time", 64'(lat), 64'(lat_a));
    kr = '0; kr[255] = 1'b1; kr[0] = 1'b1;
    run_job("kt_m0", 1'b0, kr, G, res0, launches, lat);
    check("kt_m0_R", res0, ref_mul(kr, G));
    check("kt_m0_launches", 64'(launches), 64'd256);
    run_job("kt_m1", 1'b1, kr, G, res1, launches, lat);
    check("kt_m1_R", res1, ref_mul(kr, G));
    check("kt_m1_launches", 64'(launches), 64'd256);

    // Random jobs.
    for (int j = 0; j < 6; j++) begin
      for (int w = 0; w < 8; w++) kr[w*32 +: 32] = $urandom;
      if (j < 3) kr = kr >> $urandom_range(250, 200);
      res = '{x: $urandom, y: $urandom};
      job_check($sformatf("rnd%0d", j), 1'($urandom_range(1, 0)), kr, res);
    end

    // Backpressure: result held, no new job accepted.
    in_valid = 1'b1; in_mode = 1'b0; in_k = 256'd5; in_P = G;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out("bp", lat);
    held = out_R;
    check("bp_R", held, ref_mul(256'd5, G));
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("bp_R_stable", out_R, held);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_out_valid_drop", 64'(out_valid), 64'd0);
    check("bp_in_ready_rise", 64'(in_ready), 64'd1);

    // Reset during ladder WAIT at iteration 100.
    kr = {8{32'hdead_beef}};
    in_valid = 1'b1; in_mode = 1'b1; in_k = kr; in_P = G;
    start = launch_total;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!((launch_total - start) == 100 && dut.state_r == WAIT) && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    check("mr_reached_iter100", 64'(launch_total - start), 64'd100);
    Reset_n = 1'b0;
    @(posedge clk); #1;
    Reset_n = 1'b1;
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd0);
    check("mr_out_R", out_R, inf_point);
    @(posedge clk); #1;
    check("mr_in_ready_rel", 64'(in_ready), 64'd1);
    n = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("mr_no_result", 64'(n), 64'd0);
    job_check("mr_k3", 1'b1, 256'd3, G);

    // Back-to-back with in_valid held high.
    in_valid = 1'b1; in_mode = 1'b0; in_k = 256'd6; in_P = G;
    @(posedge clk); #1;
    check("b2b_busy_a", 64'(busy), 64'd1);
    in_mode = 1'b1; in_k = 256'd5;
    wait_out("b2b_a", lat);
    check("b2b_R_a", out_R, ref_mul(256'd6, G));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("b2b_in_ready_hold", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_busy_b", 64'(busy), 64'd1);
    wait_out("b2b_b", lat);
    check("b2b_R_b", out_R, ref_mul(256'd5, G));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_done", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/point_mul_scalar_seq.md
Name: point_mul_scalar_seq

Overview:
Sequential elliptic-curve scalar multiplier R = k·P with a parametrised scalar width and a run-time selectable algorithm. Mode 0 is LSB-first double-and-add with zero-bit add skipping and early exit; it is variable-time. Mode 1 is an MSB-first Montgomery ladder with exactly K_WIDTH iterations; it is constant-time. Valid/ready handshakes on input and output let it sit behind an MSB job queue and ahead of the bucket accumulator. It reuses the existing point_add and point_double units.

Parameters:
K_WIDTH, 256, scalar width in bits (≥2)
CNT_W, $clog2(K_WIDTH+1), iteration counter width (derived; do not override)

Ports:
clk  in  1  clock
Reset_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
in_valid  in  1  job offered
in_ready  out  1  block can accept job (IDLE)
in_mode  in  1  0 = double-and-add, 1 = Montgomery ladder
in_P  in  curve_point_t  base point
in_k  in  K_WIDTH  scalar
out_valid  out  1  result held valid
out_ready  in  1  consumer accepts result
out_R  out  curve_point_t  k·P
busy  out  1  job in flight (LOAD, LAUNCH, WAIT, STEP)

Behaviour:
- Reset_n=0 at a clock edge forces IDLE, in_ready=0 for that cycle, out_valid=0, busy=0, out_R=inf_point, counter=0, sub-unit local reset=1. Applies mid-job: the job is discarded and no out_valid is produced. in_ready=1 from the first cycle after reset release.
- Accept on in_valid&&in_ready. Latch P, k, mode. Go to LOAD.
- LOAD (1 cycle):
  - Mode 0: A=inf, J=P, counter=0.
  - Mode 1: R0=inf, R1=P, counter=K_WIDTH-1 (bit index).
  - Shortcuts, mode 0 only: k==0 → DONE with inf_point; k==1 → DONE with P.
  - Mode 1 never takes shortcuts, so its latency is independent of k.
- LAUNCH (1 cycle): assert local reset to point_add/point_double with the operands muxed.
  - Mode 0: add(A,J), double(J).
  - Mode 1: bit=1 → add(R0,R1), double(R1); bit=0 → add(R0,R1), double(R0).
- WAIT: hold operands stable; local reset=0. Leave only when both Done are high.
  - Mode 1 always waits for both units.
  - Mode 0 waits for the add only when k[counter]=1.
- STEP (1 cycle), register updates:
  - Mode 0: J←double; if bit, A←add; counter+1.
  - Mode 1, bit=1: R0←add, R1←double.
  - Mode 1, bit=0: R1←add, R0←double.
  - Mode 1: counter−1.
- Termination checked in STEP:
  - Mode 0 finishes when counter+1==K_WIDTH, or when (k>>(counter+1))==0 (early exit). No trailing doubles are consumed.
  - Mode 1 finishes after the bit-0 iteration.
  - Otherwise return to LAUNCH.
- DONE: out_R = A (mode 0) or R0 (mode 1). out_valid=1. out_R is stable while out_valid&&!out_ready. On out_ready, go to IDLE with out_valid=0; in_ready rises the next cycle.
- No job overlap; exactly one result per accepted job.
- point_add must return the other operand when one input is inf_point. Mode-1 correctness relies on this.
- Counter uses no wrap; mode-1 decrement from 0 never occurs because of the exit check.
- Iteration count:
  - Mode 1: exactly K_WIDTH LAUNCH pulses.
  - Mode 0: floor(log2 k)+1 LAUNCH pulses for k≥2.

Decomposition:
- elliptic_curve_structs already holds curve_point_t and inf_point. Add these to it: a mul_mode_e enum (MUL_DAA=0, MUL_LADDER=1) and a mul_state_e enum (IDLE, LOAD, LAUNCH, WAIT, STEP, DONE).
- One new sub-module, point_mul_operand_mux: combinational selection of add/double operands and next-state register values from mode and bit. The FSM, counter and handshake stay in the top.
- Instantiate point_add and point_double unchanged; drive their active-high Reset from the FSM local reset.

Test Plan:
- k=0, mode 0, P=G → out_R=inf_point at DONE; zero LAUNCH pulses. Same job in mode 1 → inf_point after exactly K_WIDTH LAUNCH pulses.
- k=1, mode 0 → out_R=G, out_valid 2 cycles after accept. k=2 → out_R equals standalone point_double(G).
- k=0x0B and k=2^255+1, both modes → results equal each other and the software model.
  - Mode 1 LAUNCH count = 256 for both scalars.
  - Mode 0 LAUNCH counts = 4 and 256.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → out_R stable, in_ready=0. Then a pulse of out_ready → out_valid drops, in_ready=1 next cycle.
- Reset_n=0 for one cycle during mode-1 WAIT at iteration 100 → next cycle IDLE, no out_valid. A fresh job k=3 then returns 3G.
- Back-to-back jobs with in_valid held high → second job accepted only after the first out_valid/out_ready handshake. Results return in order.
